div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle divider.
// Handles divide-by-zero and signed overflow locally, times out a stuck divider and supports flush.
module div_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        sys_clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [63:0] req_dividend_i,
    input  logic [63:0] req_divisor_i,
    input  logic [1:0]  req_unsign_i,
    input  logic [1:0]  req_mod_i,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_err_o,
    output logic        div_enable_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    output logic        div_unsign_o,
    output logic        div_mod_o,
    input  logic [31:0] div_result_i,
    input  logic        div_done_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            id_q, id_d;
    logic [31:0]     dvd_q, dvd_d;
    logic [31:0]     dvs_q, dvs_d;
    logic            uns_q, uns_d;
    logic            mod_q, mod_d;
    logic [31:0]     res_q, res_d;
    logic            err_q, err_d;

    logic            grantId;
    logic            handshake;
    logic [31:0]     selDvd, selDvs;
    logic            selUns, selMod;
    logic            divZero, sgnOvf;

    // ptr_q names the favoured requester; it only matters when both are requesting.
    always_comb begin
        req_ready_o = 2'b00;
        grantId     = (&req_valid_i) ? ptr_q : req_valid_i[1];
        if (rst_ni && (state_q == IDLE) && !flush_i && (|req_valid_i)) begin
            req_ready_o = grantId ? 2'b10 : 2'b01;
        end
    end

    assign handshake = |(req_valid_i & req_ready_o);

    assign selDvd = grantId ? req_dividend_i[63:32] : req_dividend_i[31:0];
    assign selDvs = grantId ? req_divisor_i[63:32]  : req_divisor_i[31:0];
    assign selUns = grantId ? req_unsign_i[1]       : req_unsign_i[0];
    assign selMod = grantId ? req_mod_i[1]          : req_mod_i[0];

    assign divZero = (selDvs == 32'd0);
    assign sgnOvf  = !selUns && (selDvd == 32'h8000_0000) && (selDvs == 32'hFFFF_FFFF);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        uns_d   = uns_q;
        mod_d   = mod_q;
        res_d   = res_q;
        err_d   = err_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        id_d  = grantId;
                        ptr_d = ~grantId;
                        dvd_d = selDvd;
                        dvs_d = selDvs;
                        uns_d = selUns;
                        mod_d = selMod;
                        cnt_d = '0;
                        err_d = 1'b0;
                        // Corner cases the divider is never asked to compute
                        if (divZero) begin
                            res_d   = selMod ? selDvd : 32'hFFFF_FFFF;
                            state_d = RESP;
                        end else if (sgnOvf) begin
                            res_d   = selMod ? 32'd0 : 32'h8000_0000;
                            state_d = RESP;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (div_done_i) begin
                        res_d   = div_result_i;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        res_d   = 32'd0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RESP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            uns_q   <= 1'b0;
            mod_q   <= 1'b0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            uns_q   <= uns_d;
            mod_q   <= mod_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o    = (state_q == RESP) && !flush_i;
    assign rsp_id_o       = id_q;
    assign rsp_result_o   = res_q;
    assign rsp_err_o      = err_q;
    assign div_enable_o   = (state_q == BUSY);
    assign div_dividend_o = dvd_q;
    assign div_divisor_o  = dvs_q;
    assign div_unsign_o   = uns_q;
    assign div_mod_o      = mod_q;

endmodule
